// File: rtl/hack_kbd_pkg.sv
// rtl/hack_kbd_pkg.sv - Hack key codes, scan-code prefixes and PS/2 frame state encoding
package hack_kbd_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [15:0] KEY_SPACE = 16'd32;
  localparam logic [15:0] KEY_ENTER = 16'd128;
  localparam logic [15:0] KEY_BKSP  = 16'd129;
  localparam logic [15:0] KEY_LEFT  = 16'd130;
  localparam logic [15:0] KEY_UP    = 16'd131;
  localparam logic [15:0] KEY_RIGHT = 16'd132;
  localparam logic [15:0] KEY_DOWN  = 16'd133;
  localparam logic [15:0] KEY_HOME  = 16'd134;
  localparam logic [15:0] KEY_END   = 16'd135;
  localparam logic [15:0] KEY_DEL   = 16'd139;
  localparam logic [15:0] KEY_ESC   = 16'd140;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/hack_ps2_rx.sv
// rtl/hack_ps2_rx.sv - PS/2 receiver: synchronisers, clock glitch filter, frame FSM and inter-edge timeout
module hack_ps2_rx
  import hack_kbd_pkg::*;
#(
  parameter int CLK_HZ     = 16000000,
  parameter int TIMEOUT_US = 200,
  parameter int FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       rx_error
);

  // product exceeds 32 bits at realistic clock rates, so compute in 64
  localparam int TO_CYC = int'((64'(TIMEOUT_US) * 64'(CLK_HZ)) / 64'd1000000);
  localparam int TO_W   = $clog2(TO_CYC + 1);
  localparam int FL_W   = $clog2(FILTER_LEN + 1);

  logic clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic filt_q, filt_d, fall_q, fall_d;
  logic [FL_W-1:0] fcnt_q, fcnt_d;

  rx_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, byte_q, byte_d;
  logic par_q, par_d, done_q, done_d, err_q, err_d;
  logic [TO_W-1:0] timer_q, timer_d;

  // two-flop synchronisers; idle PS/2 lines are high
  always_comb begin
    clk_s1_d = ps2_clk;
    clk_s2_d = clk_s1_q;
    dat_s1_d = ps2_data;
    dat_s2_d = dat_s1_q;
  end

  // accept a clock level change only after FILTER_LEN consecutive differing samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall_d = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FL_W'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
        fall_d = filt_q;
      end else begin
        fcnt_d = fcnt_q + FL_W'(1);
      end
    end
  end

  // frame FSM advances on each filtered falling edge; the timer aborts stalled frames
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    byte_d    = byte_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    timer_d   = '0;
    if (fall_q) begin
      case (state_q)
        RX_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = RX_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        RX_DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d   = dat_s2_q;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          state_d = RX_IDLE;
          if (dat_s2_q && (^{shift_q, par_q})) begin
            done_d = 1'b1;
            byte_d = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (state_q != RX_IDLE) begin
      if (timer_q == TO_W'(TO_CYC - 1)) begin
        err_d   = 1'b1;
        state_d = RX_IDLE;
      end else begin
        timer_d = timer_q + TO_W'(1);
      end
    end
  end

  // state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      filt_q    <= 1'b1;
      fcnt_q    <= '0;
      fall_q    <= 1'b0;
      state_q   <= RX_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      par_q     <= 1'b0;
      byte_q    <= 8'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      timer_q   <= '0;
    end else begin
      clk_s1_q  <= clk_s1_d;
      clk_s2_q  <= clk_s2_d;
      dat_s1_q  <= dat_s1_d;
      dat_s2_q  <= dat_s2_d;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      fall_q    <= fall_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      byte_q    <= byte_d;
      done_q    <= done_d;
      err_q     <= err_d;
      timer_q   <= timer_d;
    end
  end

  assign rx_byte   = byte_q;
  assign byte_done = done_q;
  assign rx_error  = err_q;

endmodule

// File: rtl/hack_kbd_ps2.sv
// rtl/hack_kbd_ps2.sv - PS/2 set-2 decoder producing the Hack kbd word; optional HACK_KBD_SHIFT_EN gives shift-aware letters
module hack_kbd_ps2
  import hack_kbd_pkg::*;
#(
  parameter int CLK_HZ     = 16000000,
  parameter int TIMEOUT_US = 200,
  parameter int FILTER_LEN = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] kbd,
  output logic        key_valid,
  output logic        rx_error
);

  logic [7:0]  rx_byte;
  logic        byte_done;
  logic        brk_q, brk_d, ext_q, ext_d, kv_q, kv_d;
  logic [15:0] kbd_q, kbd_d, code, make_code;
  logic        brk_hit;

  hack_ps2_rx #(
    .CLK_HZ    (CLK_HZ),
    .TIMEOUT_US(TIMEOUT_US),
    .FILTER_LEN(FILTER_LEN)
  ) u_rx (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte),
    .byte_done(byte_done),
    .rx_error (rx_error)
  );

  // set-2 to Hack translation; letters come out upper case, 0 means unknown
  always_comb begin
    code = 16'd0;
    if (ext_q) begin
      case (rx_byte)
        8'h6B: code = KEY_LEFT;
        8'h75: code = KEY_UP;
        8'h74: code = KEY_RIGHT;
        8'h72: code = KEY_DOWN;
        8'h6C: code = KEY_HOME;
        8'h69: code = KEY_END;
        8'h71: code = KEY_DEL;
        default: code = 16'd0;
      endcase
    end else begin
      case (rx_byte)
        8'h1C: code = 16'd65;  8'h32: code = 16'd66;  8'h21: code = 16'd67;
        8'h23: code = 16'd68;  8'h24: code = 16'd69;  8'h2B: code = 16'd70;
        8'h34: code = 16'd71;  8'h33: code = 16'd72;  8'h43: code = 16'd73;
        8'h3B: code = 16'd74;  8'h42: code = 16'd75;  8'h4B: code = 16'd76;
        8'h3A: code = 16'd77;  8'h31: code = 16'd78;  8'h44: code = 16'd79;
        8'h4D: code = 16'd80;  8'h15: code = 16'd81;  8'h2D: code = 16'd82;
        8'h1B: code = 16'd83;  8'h2C: code = 16'd84;  8'h3C: code = 16'd85;
        8'h2A: code = 16'd86;  8'h1D: code = 16'd87;  8'h22: code = 16'd88;
        8'h35: code = 16'd89;  8'h1A: code = 16'd90;
        8'h45: code = 16'd48;  8'h16: code = 16'd49;  8'h1E: code = 16'd50;
        8'h26: code = 16'd51;  8'h25: code = 16'd52;  8'h2E: code = 16'd53;
        8'h36: code = 16'd54;  8'h3D: code = 16'd55;  8'h3E: code = 16'd56;
        8'h46: code = 16'd57;
        8'h29: code = KEY_SPACE;
        8'h5A: code = KEY_ENTER;
        8'h66: code = KEY_BKSP;
        8'h76: code = KEY_ESC;
        default: code = 16'd0;
      endcase
    end
  end

`ifdef HACK_KBD_SHIFT_EN
  logic shift_q, shift_d, is_letter, is_shift;

  // lower-case letters unless shift is held; a break releases either case
  always_comb begin
    is_letter = (code >= 16'd65) && (code <= 16'd90);
    is_shift  = !ext_q && ((rx_byte == 8'h12) || (rx_byte == 8'h59));
    make_code = (is_letter && !shift_q) ? code + 16'd32 : code;
    brk_hit   = (kbd_q == code) || (is_letter && (kbd_q == code + 16'd32));
    shift_d   = shift_q;
    if (byte_done && is_shift) shift_d = !brk_q;
  end

  // shift-held flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) shift_q <= 1'b0;
    else          shift_q <= shift_d;
  end
`else
  // letters are always upper case; only an exact code match releases
  always_comb begin
    make_code = code;
    brk_hit   = (kbd_q == code);
  end
`endif

  // prefix flags and kbd update on each received byte
  always_comb begin
    brk_d = brk_q;
    ext_d = ext_q;
    kbd_d = kbd_q;
    if (byte_done) begin
      if (rx_byte == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (code != 16'd0) begin
          if (!brk_q)       kbd_d = make_code;
          else if (brk_hit) kbd_d = 16'd0;
        end
      end
    end
    kv_d = (kbd_d != kbd_q);
  end

  // decode registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      brk_q <= 1'b0;
      ext_q <= 1'b0;
      kbd_q <= 16'd0;
      kv_q  <= 1'b0;
    end else begin
      brk_q <= brk_d;
      ext_q <= ext_d;
      kbd_q <= kbd_d;
      kv_q  <= kv_d;
    end
  end

  assign kbd       = kbd_q;
  assign key_valid = kv_q;

endmodule
